uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that responds to the single-cycle ARM core's data-memory port (MemWrite, DataAdr, WriteData, ReadData) as a peripheral beside dmem. Stores written bytes in a small FIFO and serialises them as 8N1 frames, LSB first, on a single output line. Exposes a status register so software can poll with LDR and branch on the result. Top level muxes ReadData from this block whenever Hit is high.

---
 rtl/uart_tx_mmio.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter for the core's data-memory port.
// TXDATA pushes a byte into a small FIFO; STATUS exposes {ovf, busy, full, empty}.
module uart_tx_mmio #(
  parameter logic [31:0] BASE  = 32'h0000_0080,
  parameter int unsigned DIV   = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        tx
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] baud;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          ovf;

  logic empty;
  logic full;
  logic busy;
  logic push_req;
  logic push;
  logic pop;
  logic ovf_clr;
  logic baud_done;
  logic unused;

  // Address decode and status bits
  assign Hit       = (DataAdr[31:3] == BASE[31:3]);
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign busy      = (state != IDLE);
  assign push_req  = MemWrite & Hit & ~DataAdr[2];
  assign push      = push_req & ~full;
  assign pop       = (state == IDLE) & ~empty;
  assign ovf_clr   = MemWrite & Hit & DataAdr[2] & WriteData[3];
  assign baud_done = (baud == BAUD_LAST);
  assign unused    = ^{WriteData[31:8], DataAdr[1:0]};

  // Zero-latency read path, like dmem
  always_comb begin
    ReadData = 32'd0;
    if (Hit && DataAdr[2]) begin
      ReadData = {28'd0, ovf, busy, full, empty};
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= WriteData[7:0];
    end
  end

  // Pointers carry one wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
    end
  end

  // Overflow is sticky: a full-FIFO push drops the byte even if a pop happens on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (push_req && full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Serialiser; tx is registered and loaded with the level of the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= 8'd0;
      bit_cnt <= 3'd0;
      baud    <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift   <= mem[rd_ptr[AW-1:0]];
            bit_cnt <= 3'd0;
            baud    <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud  <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud  <= '0;
            shift <= {1'b0, shift[7:1]};
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= IDLE;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: cycle-level queue model of FIFO/line timing plus a
// line monitor that decodes frames and checks them against the expected-frame queue.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h0000_0080;
  localparam int          DIV   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;
  logic        tx;

  uart_tx_mmio #(.BASE(BASE), .DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .MemWrite(MemWrite),
    .DataAdr(DataAdr),
    .WriteData(WriteData),
    .ReadData(ReadData),
    .Hit(Hit),
    .tx(tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    else n_pass++;
  endtask

  // Reference model: FIFO as a queue; a frame launched at edge p frees the line for a new pop at p+FRAME+1
  typedef struct {
    logic [7:0] b;
    int         t;
  } frame_t;

  logic [7:0] mq[$];
  frame_t     sb[$];
  bit         m_ovf = 1'b0;
  int         idle_from = 0;

  function automatic bit addr_hit(input logic [31:0] a);
    return a[31:3] == BASE[31:3];
  endfunction

  function automatic logic [3:0] m_status();
    bit busy;
    busy = (cyc + 1 < idle_from);
    return {m_ovf, busy, mq.size() == DEPTH, mq.size() == 0};
  endfunction

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_ovf     = 1'b0;
    idle_from = 0;
  endtask

  task automatic model_edge();
    bit hit;
    bit was_full;
    bit was_empty;
    frame_t f;
    hit       = addr_hit(DataAdr);
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (!was_empty && cyc >= idle_from) begin
      f.b = mq.pop_front();
      f.t = cyc;
      sb.push_back(f);
      idle_from = cyc + FRAME + 1;
    end
    if (MemWrite && hit && !DataAdr[2]) begin
      if (was_full) m_ovf = 1'b1;
      else mq.push_back(WriteData[7:0]);
    end
    if (MemWrite && hit && DataAdr[2] && WriteData[3]) m_ovf = 1'b0;
  endtask

  // Per-edge model update and bus/idle-line checks
  always @(posedge clk) begin
    logic [3:0]  st;
    logic [31:0] exp_rd;
    #1;
    if (!reset) begin
      model_edge();
      st     = m_status();
      exp_rd = (addr_hit(DataAdr) && DataAdr[2]) ? {28'd0, st} : 32'd0;
      chk("hit", 32'(Hit), 32'(addr_hit(DataAdr)));
      chk("read_data", ReadData, exp_rd);
      if (!st[2]) chk("tx_idle", 32'(tx), 32'd1);
    end
  end

  // Line monitor: decode 8N1 frames at bit midpoints and score against the model
  bit         in_frame = 1'b0;
  int         pos = 0;
  int         start_cyc = 0;
  logic [7:0] sh = 8'd0;

  always @(posedge clk) begin
    frame_t f;
    #1;
    if (reset) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx == 1'b0) begin
        in_frame  = 1'b1;
        pos       = 0;
        start_cyc = cyc;
        sh        = 8'd0;
      end
    end else begin
      pos++;
      if (pos == DIV / 2) chk("start_bit", 32'(tx), 32'd0);
      if (pos >= DIV && pos < 9 * DIV && (pos % DIV) == DIV / 2) sh = {tx, sh[7:1]};
      if (pos == 9 * DIV + DIV / 2) begin
        chk("stop_bit", 32'(tx), 32'd1);
        chk("frame_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          f = sb.pop_front();
          chk("frame_data", 32'(sh), 32'(f.b));
          chk("frame_start_cycle", 32'(start_cyc), 32'(f.t));
        end
      end
      if (pos == FRAME - 1) in_frame = 1'b0;
    end
  end

  // One bus cycle: drive at negedge, return 2 time units after the following posedge
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] data);
    @(negedge clk);
    MemWrite  = we;
    DataAdr   = adr;
    WriteData = data;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, BASE + 32'd4, 32'd0);
  endtask

  initial begin
    logic [31:0] adr;
    int          r;
    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = BASE + 32'd4;
    WriteData = 32'd0;
    repeat (3) @(negedge clk);
    chk("tx_in_reset", 32'(tx), 32'd1);
    reset = 1'b0;

    // Reset state and decode window
    idle(1);
    chk("status_after_reset", ReadData, 32'h0000_0001);
    bus(1'b0, BASE + 32'd8, 32'd0);
    chk("hit_outside", 32'(Hit), 32'd0);

    // Single frame
    bus(1'b1, BASE, 32'h0000_00A5);
    idle(2);
    chk("status_in_frame", ReadData, 32'h0000_0005);
    idle(FRAME + 2);
    chk("status_after_frame", ReadData, 32'h0000_0001);

    // Overflow burst, then clear ovf
    for (int i = 1; i <= 6; i++) bus(1'b1, BASE, 32'(i));
    idle(1);
    chk("status_overflow", ReadData, 32'h0000_000E);
    bus(1'b1, BASE + 32'd4, 32'h0000_0008);
    chk("status_ovf_cleared", ReadData, 32'h0000_0006);
    idle(6 * (FRAME + 1));

    // Reset in the middle of a data bit (data 0x00 keeps the line low)
    bus(1'b1, BASE, 32'h0000_0000);
    bus(1'b1, BASE, 32'h0000_0033);
    idle(7);
    chk("tx_low_in_data", 32'(tx), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("tx_async_reset", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(1);
    chk("status_after_midreset", ReadData, 32'h0000_0001);
    idle(FRAME);

    // Out-of-window writes
    bus(1'b1, BASE + 32'h10, 32'h0000_00FF);
    chk("hit_above", 32'(Hit), 32'd0);
    bus(1'b1, BASE - 32'd4, 32'h0000_0000);
    chk("hit_below", 32'(Hit), 32'd0);
    idle(FRAME);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 11));
      if (r <= 2) begin
        bus(1'b1, BASE + 32'($urandom_range(0, 3)), $urandom());
      end else if (r == 3) begin
        bus(1'b1, BASE + 32'd4 + 32'($urandom_range(0, 3)), $urandom());
      end else if (r == 4) begin
        adr = $urandom();
        if (addr_hit(adr)) adr = adr ^ 32'h0000_0100;
        bus(1'b1, adr, $urandom());
      end else if (r == 5) begin
        bus(1'b0, BASE, 32'd0);
      end else begin
        idle(1);
      end
    end

    idle((DEPTH + 2) * (FRAME + 1));
    chk("frames_drained", 32'(sb.size()), 32'd0);
    chk("fifo_drained", 32'(mq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
